// File: rtl/rega_pkg.sv
// rega_pkg: shared state encoding, digit maxima and preset clamp for the irrigation timer.
package rega_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        PAUSE = ST_PAUSE,
        DONE  = ST_DONE
    } state_t;
    localparam logic [3:0] MAX_USEC = 4'd9;
    localparam logic [3:0] MAX_DSEC = 4'd5;
    localparam logic [3:0] MAX_MIN  = 4'd9;
    function automatic logic [3:0] clamp_bcd(input logic [3:0] v, input logic [3:0] mx);
        return (v > mx) ? mx : v;
    endfunction
endpackage

// File: rtl/bcd_down_digit.sv
// bcd_down_digit: loadable BCD down-counter digit that wraps 0 -> MAX and flags the borrow.
module bcd_down_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic [3:0] q,
    output logic       borrow
);
    logic [3:0] q_q, q_d;
    always_comb begin
        q_d = load ? load_val : en ? ((q_q == 4'd0) ? MAX : q_q - 4'd1) : q_q;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) q_q <= 4'd0;
        else       q_q <= q_d;
    end
    assign q      = q_q;
    assign borrow = en & (q_q == 4'd0);
endmodule

// File: rtl/rega_timer_ctrl.sv
// rega_timer_ctrl: M:SS irrigation countdown sequencer with 1 Hz prescaler,
// BCD borrow chain and valve/busy/done decode from the state register.
module rega_timer_ctrl
    import rega_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int          PSC_W         = 26
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       abort,
    input  logic [3:0] min_set,
    input  logic [3:0] dsec_set,
    input  logic [3:0] usec_set,
    output logic [3:0] q_min,
    output logic [3:0] q_dsec,
    output logic [3:0] q_usec,
    output logic       valve,
    output logic       busy,
    output logic       done
);
    state_t             state_q, state_d;
    logic [PSC_W-1:0]   psc_q, psc_d;
    logic [3:0]         pre_min, pre_dsec, pre_usec;
    logic               load, tick, nonzero, is_last, dig_en;
    logic               borrow_u, borrow_d, borrow_m;

    assign pre_min  = clamp_bcd(min_set, MAX_MIN);
    assign pre_dsec = clamp_bcd(dsec_set, MAX_DSEC);
    assign pre_usec = clamp_bcd(usec_set, MAX_USEC);
    assign load     = abort | (state_q == IDLE && start);
    assign tick     = state_q == RUN && !abort && !pause && psc_q == PSC_W'(TICKS_PER_SEC - 1);
    assign nonzero  = |{q_min, q_dsec, q_usec};
    assign is_last  = q_min == 4'd0 && q_dsec == 4'd0 && q_usec == 4'd1;
    assign dig_en   = tick & nonzero;

    always_comb begin
        state_d = state_q;
        psc_d   = psc_q;
        if (abort) begin
            state_d = IDLE;
            psc_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_d = |{pre_min, pre_dsec, pre_usec} ? RUN : DONE;
                    psc_d   = '0;
                end
                RUN: begin
                    // pause outranks the tick, so a terminal count is held until resume
                    state_d = pause ? PAUSE : (tick && (is_last || borrow_m)) ? DONE : RUN;
                    psc_d   = pause ? psc_q : tick ? '0 : psc_q + PSC_W'(1);
                end
                PAUSE:   state_d = pause ? PAUSE : RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            psc_q   <= '0;
        end else begin
            state_q <= state_d;
            psc_q   <= psc_d;
        end
    end

    bcd_down_digit #(.MAX(MAX_USEC)) u_usec (
        .clock(clock), .reset(reset), .load(load), .load_val(abort ? 4'd0 : pre_usec),
        .en(dig_en), .q(q_usec), .borrow(borrow_u)
    );
    bcd_down_digit #(.MAX(MAX_DSEC)) u_dsec (
        .clock(clock), .reset(reset), .load(load), .load_val(abort ? 4'd0 : pre_dsec),
        .en(borrow_u), .q(q_dsec), .borrow(borrow_d)
    );
    bcd_down_digit #(.MAX(MAX_MIN)) u_min (
        .clock(clock), .reset(reset), .load(load), .load_val(abort ? 4'd0 : pre_min),
        .en(borrow_d), .q(q_min), .borrow(borrow_m)
    );

    assign valve = state_q == RUN;
    assign busy  = state_q == RUN || state_q == PAUSE;
    assign done  = state_q == DONE;
endmodule

// File: tb/tb_rega_timer_ctrl.sv
// tb_rega_timer_ctrl: scoreboard bench; a seconds-based reference model predicts every cycle.
module tb_rega_timer_ctrl;
    localparam int T = 4;

    logic       clock = 1'b0, reset = 1'b1;
    logic       start = 1'b0, pause = 1'b0, abort = 1'b0;
    logic [3:0] min_set = '0, dsec_set = '0, usec_set = '0;
    logic [3:0] q_min, q_dsec, q_usec;
    logic       valve, busy, done;

    rega_timer_ctrl #(.TICKS_PER_SEC(T), .PSC_W(3)) dut (
        .clock(clock), .reset(reset), .start(start), .pause(pause), .abort(abort),
        .min_set(min_set), .dsec_set(dsec_set), .usec_set(usec_set),
        .q_min(q_min), .q_dsec(q_dsec), .q_usec(q_usec),
        .valve(valve), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] m, d, u;
        logic       v, b, dn;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0;
    bit   mon_en = 1'b1;
    int   vcnt = 0, dcnt = 0;

    // reference model: mode 0 idle, 1 run, 2 pause, 3 done; time kept as whole seconds
    int   mode = 0, secs = 0, psc = 0;

    task automatic model_step(input logic s, p, a, input logic [3:0] m, d, u);
        int mn, dn, un;
        mn = (m > 9) ? 9 : int'(m);
        dn = (d > 5) ? 5 : int'(d);
        un = (u > 9) ? 9 : int'(u);
        if (a) begin
            mode = 0; secs = 0; psc = 0;
        end else if (mode == 0) begin
            if (s) begin
                secs = mn * 60 + dn * 10 + un;
                psc  = 0;
                mode = (secs == 0) ? 3 : 1;
            end
        end else if (mode == 1) begin
            if (p) mode = 2;
            else if (psc == T - 1) begin
                psc  = 0;
                secs = secs - 1;
                if (secs == 0) mode = 3;
            end else psc = psc + 1;
        end else if (mode == 2) begin
            if (!p) mode = 1;
        end else mode = 0;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.m  = 4'(secs / 60);
        e.d  = 4'((secs % 60) / 10);
        e.u  = 4'(secs % 10);
        e.v  = (mode == 1);
        e.b  = (mode == 1 || mode == 2);
        e.dn = (mode == 3);
        return e;
    endfunction

    task automatic step(input logic s, p, a, input logic [3:0] m, d, u);
        @(negedge clock);
        vcnt += int'(valve);
        dcnt += int'(done);
        start = s; pause = p; abort = a;
        min_set = m; dsec_set = d; usec_set = u;
        model_step(s, p, a, m, d, u);
        sb.push_back(model_out());
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e, a;
        forever begin
            @(posedge clock);
            #1;
            if (mon_en && sb.size() > 0) begin
                e = sb.pop_front();
                a = {q_min, q_dsec, q_usec, valve, busy, done};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t: got %0d:%0d%0d v%b b%b d%b, expected %0d:%0d%0d v%b b%b d%b",
                             $time, a.m, a.d, a.u, a.v, a.b, a.dn, e.m, e.d, e.u, e.v, e.b, e.dn);
                end
            end
        end
    end

    initial begin : stim
        repeat (3) @(negedge clock);
        check("reset_held", int'({q_min, q_dsec, q_usec, valve, busy, done}), 0);
        reset = 1'b0;
        @(negedge clock);
        check("reset_released", int'({q_min, q_dsec, q_usec, valve, busy, done}), 0);

        // 0:12 run
        vcnt = 0; dcnt = 0;
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 4'd2);
        idle_steps(55);
        check("valve_0_12", vcnt, 48);
        check("done_0_12", dcnt, 1);

        // 1:00 run with min/dsec borrow chain
        vcnt = 0; dcnt = 0;
        step(1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 4'd0);
        idle_steps(250);
        check("valve_1_00", vcnt, 240);
        check("done_1_00", dcnt, 1);

        // 0:05 with a pause landing on the terminal prescaler count
        dcnt = 0;
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd5);
        idle_steps(3);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        idle_steps(30);
        check("done_pause", dcnt, 1);

        // 0:30 aborted at 0:17
        dcnt = 0;
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 4'd0);
        idle_steps(53);
        step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        idle_steps(5);
        check("done_abort", dcnt, 0);

        // 0:00 preset, then clamped preset and ignored restart
        vcnt = 0; dcnt = 0;
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
        idle_steps(3);
        check("valve_zero", vcnt, 0);
        check("done_zero", dcnt, 1);
        step(1'b1, 1'b0, 1'b0, 4'hF, 4'd7, 4'hC);
        idle_steps(10);
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 4'd3);
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 4'd3);
        idle_steps(10);
        step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        idle_steps(2);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0,
                 4'($urandom_range(0, 15) > 12 ? $urandom_range(0, 15) : $urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        idle_steps(2);

        // asynchronous reset while running
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 4'd0);
        idle_steps(6);
        @(posedge clock);
        #2;
        check("valve_before_reset", int'(valve), 1);
        mon_en = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("valve_async_reset", int'(valve), 0);
        check("busy_async_reset", int'(busy), 0);
        check("digits_async_reset", int'({q_min, q_dsec, q_usec}), 0);
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
